// File: rtl/router_1xn.sv
// router_1xn: accepts header/payload/parity byte packets from one source
// and steers each packet into one of NUM_PORTS output FIFOs. Illegal
// addresses are dropped. Parity errors are flagged but the bytes are kept.
// A channel that is left unread for TIMEOUT cycles is flushed.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          packet_valid,
  input  logic [DATA_W-1:0]             datain,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out,
  output logic [NUM_PORTS-1:0]          vld_out,
  output logic                          busy,
  output logic                          err,
  output logic                          addr_err,
  output logic [NUM_PORTS-1:0]          soft_reset
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int REM_W = LEN_W + 1;           // holds len+1 while dropping
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_DATA,
    LOAD_PARITY,
    DROP
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   target_reg, target_next;
  logic [REM_W-1:0]    rem_reg, rem_next;
  logic [DATA_W-1:0]   parity_reg, parity_next;
  logic [DATA_W-1:0]   header_reg, header_next;
  logic                err_reg, err_next;
  logic                addr_err_reg, addr_err_next;

  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] flush;

  logic                fifo_we;
  logic [DATA_W-1:0]   fifo_wdata;
  logic                tgt_full, tgt_empty, tgt_flush, hdr_empty;
  logic                accept;
  logic                hdr_legal;
  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;

  assign hdr_addr  = datain[ADDR_W-1:0];
  assign hdr_len   = datain[DATA_W-1:ADDR_W];
  assign hdr_legal = (int'(hdr_addr) < NUM_PORTS);

  // Pick out the status flags of the channel being loaded and of the
  // channel addressed by the byte currently on datain.
  always_comb begin
    tgt_full  = 1'b0;
    tgt_empty = 1'b0;
    tgt_flush = 1'b0;
    hdr_empty = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (target_reg == ADDR_W'(i)) begin
        tgt_full  = fifo_full[i];
        tgt_empty = fifo_empty[i];
        tgt_flush = flush[i];
      end
      if (hdr_addr == ADDR_W'(i)) begin
        hdr_empty = fifo_empty[i];
      end
    end
  end

  // The source must hold its byte while waiting for an empty target or
  // while the target FIFO is full.
  assign busy = (state_reg == WAIT_EMPTY) ||
                (((state_reg == LOAD_DATA) || (state_reg == LOAD_PARITY)) && tgt_full);
  assign accept = packet_valid && !busy;

  // FSM state register and the registered error pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      target_reg   <= '0;
      rem_reg      <= '0;
      parity_reg   <= '0;
      header_reg   <= '0;
      err_reg      <= 1'b0;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      target_reg   <= target_next;
      rem_reg      <= rem_next;
      parity_reg   <= parity_next;
      header_reg   <= header_next;
      err_reg      <= err_next;
      addr_err_reg <= addr_err_next;
    end
  end

  // Next-state logic: header decode, payload countdown, parity check and
  // reaction to a flush of the channel being loaded.
  always_comb begin
    state_next    = state_reg;
    target_next   = target_reg;
    rem_next      = rem_reg;
    parity_next   = parity_reg;
    header_next   = header_reg;
    err_next      = 1'b0;
    addr_err_next = 1'b0;
    fifo_we       = 1'b0;
    fifo_wdata    = datain;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          target_next = hdr_addr;
          header_next = datain;
          parity_next = datain;
          if (!hdr_legal) begin
            addr_err_next = 1'b1;
            rem_next      = REM_W'(hdr_len) + REM_W'(1);
            state_next    = DROP;
          end else if (hdr_empty) begin
            fifo_we    = 1'b1;
            rem_next   = REM_W'(hdr_len);
            state_next = (hdr_len != '0) ? LOAD_DATA : LOAD_PARITY;
          end else begin
            rem_next   = REM_W'(hdr_len);
            state_next = WAIT_EMPTY;
          end
        end
      end
      WAIT_EMPTY: begin
        if (tgt_empty) begin
          fifo_we    = 1'b1;
          fifo_wdata = header_reg;
          state_next = (rem_reg != '0) ? LOAD_DATA : LOAD_PARITY;
        end
      end
      LOAD_DATA: begin
        if (tgt_flush) begin
          // Remaining payload plus parity are discarded.
          rem_next   = accept ? rem_reg : rem_reg + REM_W'(1);
          state_next = DROP;
        end else if (accept) begin
          fifo_we     = 1'b1;
          parity_next = parity_reg ^ datain;
          rem_next    = rem_reg - REM_W'(1);
          if (rem_reg == REM_W'(1)) begin
            state_next = LOAD_PARITY;
          end
        end
      end
      LOAD_PARITY: begin
        if (tgt_flush) begin
          if (accept) begin
            state_next = IDLE;
          end else begin
            rem_next   = REM_W'(1);
            state_next = DROP;
          end
        end else if (accept) begin
          fifo_we    = 1'b1;
          err_next   = (datain != parity_reg);
          state_next = IDLE;
        end
      end
      DROP: begin
        if (accept) begin
          rem_next = rem_reg - REM_W'(1);
          if (rem_reg == REM_W'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign err      = err_reg;
  assign addr_err = addr_err_reg;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ch
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [TMR_W-1:0]  timer_reg;
    logic [DATA_W-1:0] dout_reg;
    logic              vld_reg;
    logic              soft_reg;
    logic              wr, rd, idle_tick;

    assign fifo_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty[gi] = (count_reg == '0);
    assign wr        = fifo_we && (target_next == ADDR_W'(gi)) && !fifo_full[gi];
    assign rd        = read_enb[gi] && !fifo_empty[gi];
    assign idle_tick = vld_reg && !read_enb[gi] && !fifo_empty[gi];
    assign flush[gi] = idle_tick && (timer_reg == TMR_W'(TIMEOUT - 1));

    // Storage array write port; contents need no reset.
    always_ff @(posedge clk) begin
      if (wr) begin
        mem[wr_ptr_reg] <= fifo_wdata;
      end
    end

    // Pointers, occupancy and registered read data; flush empties the FIFO.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        dout_reg   <= '0;
      end else if (flush[gi]) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (wr) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (rd) begin
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          dout_reg   <= mem[rd_ptr_reg];
        end
        case ({wr, rd})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end

    // Valid flag, unread-cycle timer and the flush pulse.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        vld_reg   <= 1'b0;
        soft_reg  <= 1'b0;
        timer_reg <= '0;
      end else begin
        vld_reg   <= !fifo_empty[gi];
        soft_reg  <= flush[gi];
        if (flush[gi] || !idle_tick) begin
          timer_reg <= '0;
        end else begin
          timer_reg <= timer_reg + TMR_W'(1);
        end
      end
    end

    assign data_out[gi*DATA_W +: DATA_W] = dout_reg;
    assign vld_out[gi]    = vld_reg;
    assign soft_reset[gi] = soft_reg;
  end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: directed scenarios followed by random packets, checked
// against a byte-queue model of what each channel should deliver.
module tb_router_1xn;

  logic        clk;
  logic        resetn;
  logic        packet_valid;
  logic [7:0]  datain;
  logic [2:0]  read_enb;
  logic [23:0] data_out;
  logic [2:0]  vld_out;
  logic        busy;
  logic        err;
  logic        addr_err;
  logic [2:0]  soft_reset;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  router_1xn dut (
    .clk          (clk),
    .resetn       (resetn),
    .packet_valid (packet_valid),
    .datain       (datain),
    .read_enb     (read_enb),
    .data_out     (data_out),
    .vld_out      (vld_out),
    .busy         (busy),
    .err          (err),
    .addr_err     (addr_err),
    .soft_reset   (soft_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte once the router is ready; optionally record it as
  // expected channel content.
  task automatic send_byte(input logic [7:0] b, input bit keep);
    int w;
    w = 0;
    while (busy && w < 50) begin
      step();
      w++;
    end
    if (w >= 50) chk("busy_wait_bound", busy, 0);
    packet_valid = 1'b1;
    datain       = b;
    step();
    packet_valid = 1'b0;
    datain       = 8'($urandom);
    if (keep) exp_q.push_back(b);
  endtask

  // Back-to-back reads of n bytes from one port, compared with the model.
  task automatic drain(input int port, input int n);
    logic [7:0] e;
    read_enb = 3'(1 << port);
    for (int k = 0; k < n; k++) begin
      step();
      if (exp_q.size() == 0) begin
        chk("model_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 32'(data_out[port*8 +: 8]), 32'(e));
      end
    end
    read_enb = 3'b000;
  endtask

  initial begin
    int          since;
    int          port, len;
    bit          bad, legal;
    logic [7:0]  par, b;
    logic [7:0]  pkt[$];
    logic [31:0] rnd;

    resetn       = 1'b0;
    packet_valid = 1'b0;
    datain       = 8'h00;
    read_enb     = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", vld_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_soft", soft_reset, 0);
    chk("rst_dout", data_out, 0);
    resetn = 1'b1;
    step();

    // Good packet to port 1.
    send_byte(8'h0D, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    send_byte(8'h33, 1); send_byte(8'h0D, 1);
    chk("good_err", err, 0);
    chk("good_vld", vld_out, 3'b010);
    drain(1, 5);
    step();
    chk("good_vld_after", vld_out, 3'b000);

    // Same packet with a wrong parity byte.
    send_byte(8'h0D, 1); send_byte(8'h11, 1); send_byte(8'h22, 1);
    send_byte(8'h33, 1); send_byte(8'h00, 1);
    chk("bad_err_pulse", err, 1);
    step();
    chk("bad_err_end", err, 0);
    drain(1, 5);
    step();
    chk("bad_vld_after", vld_out, 3'b000);

    // Illegal address 3: dropped.
    send_byte(8'h07, 0);
    chk("drop_addr_err", addr_err, 1);
    chk("drop_busy0", busy, 0);
    send_byte(8'hAA, 0);
    chk("drop_addr_err_end", addr_err, 0);
    chk("drop_busy1", busy, 0);
    send_byte(8'h55, 0);
    chk("drop_busy2", busy, 0);
    step();
    chk("drop_vld", vld_out, 3'b000);

    // Long packet to port 0 fills the FIFO.
    par = 8'h50;
    send_byte(8'h50, 1);
    for (int i = 1; i <= 15; i++) begin
      b = 8'(i);
      par ^= b;
      send_byte(b, 1);
    end
    chk("full_busy", busy, 1);
    for (int i = 16; i <= 21; i++) begin
      read_enb = 3'b001;
      step();
      read_enb = 3'b000;
      b = exp_q.pop_front();
      chk("full_rd", 32'(data_out[7:0]), 32'(b));
      chk("full_busy_drop", busy, 0);
      if (i <= 20) begin
        b = 8'(i);
        par ^= b;
        send_byte(b, 1);
      end else begin
        send_byte(par, 1);
      end
    end
    chk("full_err", err, 0);
    drain(0, 16);
    step();
    chk("full_vld_after", vld_out, 3'b000);

    // Second packet to port 1 must wait until FIFO1 drains.
    send_byte(8'h05, 1); send_byte(8'hAA, 1); send_byte(8'h05 ^ 8'hAA, 1);
    send_byte(8'h09, 1);
    chk("wait_busy", busy, 1);
    read_enb = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      b = exp_q.pop_front();
      chk("wait_rd", 32'(data_out[15:8]), 32'(b));
      chk("wait_busy_hold", busy, 1);
    end
    read_enb = 3'b000;
    step();
    chk("wait_busy_release", busy, 0);
    send_byte(8'hBB, 1); send_byte(8'hCC, 1); send_byte(8'h09 ^ 8'hBB ^ 8'hCC, 1);
    chk("wait_err", err, 0);
    drain(1, 4);
    step();
    chk("wait_vld_after", vld_out, 3'b000);

    // Timeout flush of port 2.
    packet_valid = 1'b1;
    datain = 8'h06;
    step();
    chk("to_vld_low", vld_out[2], 0);
    datain = 8'h5A;
    step();
    chk("to_vld_rise", vld_out[2], 1);
    since = 0;
    datain = 8'h06 ^ 8'h5A;
    step();
    packet_valid = 1'b0;
    since = 1;
    while (!soft_reset[2] && since < 100) begin
      step();
      since++;
    end
    chk("to_cycles", since, 30);
    chk("to_soft", soft_reset, 3'b100);
    step();
    chk("to_vld_clear", vld_out, 3'b000);
    chk("to_soft_end", soft_reset, 3'b000);

    // Asynchronous reset in the middle of a packet, then a fresh packet.
    send_byte(8'h0C, 0);
    send_byte(8'h77, 0);
    chk("ar_vld_before", vld_out, 3'b001);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_vld", vld_out, 3'b000);
    chk("ar_busy", busy, 0);
    step();
    resetn = 1'b1;
    step();
    send_byte(8'h00, 1); send_byte(8'h00, 1);
    chk("ar_err", err, 0);
    drain(0, 2);
    step();
    chk("ar_vld_after", vld_out, 3'b000);

    // Random packets, one at a time, with source stalls.
    for (int p = 0; p < 24; p++) begin
      port  = $urandom_range(0, 3);
      len   = $urandom_range(0, 9);
      bad   = ($urandom_range(0, 3) == 0);
      legal = (port < 3);
      rnd   = 32'(len);
      pkt.delete();
      b   = {rnd[5:0], 2'(port)};
      par = b;
      pkt.push_back(b);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom);
        par ^= b;
        pkt.push_back(b);
      end
      if (bad) par ^= 8'($urandom_range(1, 255));
      pkt.push_back(par);
      for (int k = 0; k < pkt.size(); k++) begin
        if ($urandom_range(0, 1) == 1) step();
        chk("rnd_busy", busy, 0);
        packet_valid = 1'b1;
        datain = pkt[k];
        step();
        packet_valid = 1'b0;
        if (legal) exp_q.push_back(pkt[k]);
        if (k == 0) chk("rnd_addr_err", addr_err, 32'(!legal));
      end
      chk("rnd_err", err, 32'(legal && bad));
      chk("rnd_vld", vld_out, legal ? 32'(1 << port) : 32'(0));
      if (legal) drain(port, len + 2);
      step();
      chk("rnd_vld_after", vld_out, 0);
    end
    chk("model_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
